// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler for four valid/ready channels feeding a 4:1 mux, with a one-beat output register.
// Optional packet lock (channel held until in_last) is enabled by defining MUX4_RR_SCHED_LOCK_EN.
module mux4_rr_sched #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            in_valid,
  input  logic [4*DATA_W-1:0]   in_data,
`ifdef MUX4_RR_SCHED_LOCK_EN
  input  logic [3:0]            in_last,
`endif
  output logic [3:0]            in_ready,
  output logic [1:0]            sel,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_ch,
  input  logic                  out_ready
);

  // First requester after p in the order p+1, p+2, p+3, p; returns p if nobody requests.
  function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] req);
    logic [1:0] c;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      c = p + 2'(k);
      if (req[c]) rr_pick = c;
    end
  endfunction

  logic [1:0]        ptr;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [1:0]        ch_p1;

  logic              load_p0;
  logic              gnt_ok_p0;
  logic [1:0]        gnt_ch_p0;
  logic              xfer_p0;

`ifdef MUX4_RR_SCHED_LOCK_EN
  logic              locked;
  logic [1:0]        lock_ch;
`endif

  // ---- stage p0: arbitration on the live request vector ----
  always_comb begin
    load_p0   = ~vld_p1 | out_ready;
    gnt_ch_p0 = rr_pick(ptr, in_valid);
    gnt_ok_p0 = |in_valid;
`ifdef MUX4_RR_SCHED_LOCK_EN
    if (locked) begin
      gnt_ch_p0 = lock_ch;
      gnt_ok_p0 = in_valid[lock_ch];
    end
`endif
    xfer_p0  = load_p0 & gnt_ok_p0;
    in_ready = xfer_p0 ? (4'b0001 << gnt_ch_p0) : 4'b0000;
    sel      = gnt_ch_p0;
  end

  // ---- stage p1: output slot and last-grant pointer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      ch_p1   <= 2'd0;
      ptr     <= 2'b11;
    end else if (xfer_p0) begin
      vld_p1  <= 1'b1;
      data_p1 <= in_data[gnt_ch_p0*DATA_W +: DATA_W];
      ch_p1   <= gnt_ch_p0;
      ptr     <= gnt_ch_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef MUX4_RR_SCHED_LOCK_EN
  // A non-last beat pins arbitration to its channel until that channel's last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= 2'd0;
    end else if (xfer_p0) begin
      locked  <= ~in_last[gnt_ch_p0];
      lock_ch <= gnt_ch_p0;
    end
  end
`endif

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_ch    = ch_p1;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: a queue-based reference model predicts grants and
// output beats; a separate monitor pops and compares each beat the DUT hands downstream.
module tb_mux4_rr_sched;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      in_valid;
  logic [4*DW-1:0] in_data;
`ifdef MUX4_RR_SCHED_LOCK_EN
  logic [3:0]      in_last;
`endif
  logic [3:0]      in_ready;
  logic [1:0]      sel;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_ch;
  logic            out_ready;

  int checks = 0;
  int failures = 0;

  mux4_rr_sched #(.DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef MUX4_RR_SCHED_LOCK_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .sel(sel), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: who was granted last, whether the slot is full, expected beats.
  int        m_ptr = 3;
  bit        m_full = 0;
  bit        m_lock = 0;
  int        m_lock_ch = 0;
  logic [9:0] exp_q[$];

  // Model: evaluated just before each rising edge, with inputs and outputs settled.
  always begin
    int w;
    bit ok;
    bit load;
    @(negedge clk);
    #4;
    if (rst) begin
      m_ptr = 3; m_full = 0; m_lock = 0; m_lock_ch = 0;
      exp_q.delete();
    end else begin
      load = !m_full || out_ready;
      chk("out_valid", 32'(out_valid), 32'(m_full));
      w = m_ptr;
      ok = 0;
      if (m_lock) begin
        w = m_lock_ch;
        ok = in_valid[w];
      end else begin
        for (int k = 1; k <= 4; k++)
          if (!ok && in_valid[(m_ptr + k) % 4]) begin
            w = (m_ptr + k) % 4;
            ok = 1;
          end
      end
      chk("sel", 32'(sel), w);
      chk("in_ready", 32'(in_ready), (load && ok) ? (1 << w) : 0);
      if (load && ok) begin
        exp_q.push_back({w[1:0], in_data[w*DW +: DW]});
        m_ptr = w;
        m_full = 1;
`ifdef MUX4_RR_SCHED_LOCK_EN
        m_lock = !in_last[w];
        m_lock_ch = w;
`endif
      end else if (out_ready) begin
        m_full = 0;
      end
    end
  end

  // Monitor: whenever downstream takes a beat, compare it with the oldest prediction.
  always begin
    logic [9:0] e;
    @(negedge clk);
    #4;
    if (!rst && out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected actual=ch%0d/%0h required=none", out_ch, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e[7:0]));
        chk("out_ch", 32'(out_ch), 32'(e[9:8]));
      end
    end
  end

  task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic r,
                       input logic [3:0] last);
    @(negedge clk);
    #1;
    in_valid = v;
    in_data = d;
    out_ready = r;
`ifdef MUX4_RR_SCHED_LOCK_EN
    in_last = last;
`endif
  endtask

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    out_ready = 1'b0;
`ifdef MUX4_RR_SCHED_LOCK_EN
    in_last = 4'hF;
`endif
    #2;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // All channels requesting: grants rotate 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) drive(4'hF, $urandom, 1'b1, 4'hF);
    // Sole requester wins every cycle.
    for (int i = 0; i < 4; i++) drive(4'b0100, 32'h00A5_0000, 1'b1, 4'hF);
    // ch1 beat registered, then a 3-cycle stall with everyone requesting.
    drive(4'b0010, 32'h0000_3C00, 1'b1, 4'hF);
    for (int i = 0; i < 3; i++) drive(4'hF, $urandom, 1'b0, 4'hF);
    for (int i = 0; i < 3; i++) drive(4'hF, $urandom, 1'b1, 4'hF);
    // Wrap: grant ch3, then ch0/ch3 contend.
    drive(4'b1000, $urandom, 1'b1, 4'hF);
    for (int i = 0; i < 3; i++) drive(4'b1001, $urandom, 1'b1, 4'hF);

    // Randomized traffic and back-pressure.
    for (int i = 0; i < 3000; i++)
      drive(4'($urandom), $urandom, ($urandom_range(0, 3) != 0), 4'($urandom));

    // Reset while a beat is stalled in the slot.
    drive(4'b0010, $urandom, 1'b1, 4'hF);
    drive(4'hF, $urandom, 1'b0, 4'hF);
    drive(4'hF, $urandom, 1'b0, 4'hF);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_out_valid", 32'(out_valid), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_sel", 32'(sel), 0);
    for (int i = 0; i < 6; i++) drive(4'hF, $urandom, 1'b1, 4'hF);

    // Drain.
    for (int i = 0; i < 4; i++) drive(4'h0, '0, 1'b1, 4'hF);
    @(negedge clk);
    #6;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
